// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative multiply/divide unit beside the ALU in the EX stage. It owns the
// HI/LO registers and runs MULT, MULTU, DIV and DIVU:
//   - multiply: 32 iterations of shift-add on a 65-bit accumulator
//   - divide:   32 iterations of restoring division on remainder:quotient
// Signed operations work on magnitudes. A final FIX cycle applies the sign
// correction and writes HI/LO. While an operation is in flight the unit asks
// the hazard logic to stall any instruction that would touch it.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   start        issue the operation selected by op
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   data1        rs operand (multiplicand / dividend), also MTHI/MTLO data
//   data2        rt operand (multiplier / divisor)
//   hi_we        MTHI: HI <= data1 (only honoured when idle)
//   lo_we        MTLO: LO <= data1 (only honoured when idle)
//   hilo_rd      EX instruction is MFHI/MFLO
//   busy         operation in flight
//   stall        combinational; freeze IF/ID/EX
//   done         one-cycle pulse when HI/LO have been updated
//   div_by_zero  one-cycle pulse together with done on a divide by zero
//   hi, lo       HI and LO registers
// -----------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32   // iterations per operation; must equal WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic             hilo_rd,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int ACC_W = 2 * WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    // Multiply: [2W:W] running sum (with carry), [W-1:0] multiplier.
    // Divide:   [2W-1:W] remainder, [W-1:0] dividend shifting into quotient.
    logic [ACC_W-1:0] acc_q;
    logic [WIDTH-1:0] opnd_q;       // multiplicand or divisor magnitude
    logic             is_div_q;
    logic             neg_q;        // product / quotient must be negated
    logic             rem_neg_q;    // remainder must be negated
    logic             dbz_q;        // FIX entered on divide by zero
    logic             busy_q;
    logic             done_q;
    logic             div_by_zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    // -------------------------------------------------------------------------
    // Operand decode at issue
    // -------------------------------------------------------------------------
    logic             op_is_div;
    logic             sgn1;
    logic             sgn2;
    logic [WIDTH-1:0] mag1;
    logic [WIDTH-1:0] mag2;

    // NOTE: every signal driven in an always_comb gets a value first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        op_is_div = op[1];
        sgn1      = ~op[0] & data1[WIDTH-1];
        sgn2      = ~op[0] & data2[WIDTH-1];
        // Two's-complement negate of the most negative value yields the same
        // bit pattern, which is exactly its unsigned magnitude.
        mag1      = sgn1 ? -data1 : data1;
        mag2      = sgn2 ? -data2 : data2;
    end

    // -------------------------------------------------------------------------
    // One iteration of each algorithm
    // -------------------------------------------------------------------------
    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_next;
    logic [WIDTH:0]   div_rem_sh;   // remainder after the left shift, W+1 bits
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [ACC_W-1:0] div_next;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        if (acc_q[0]) begin
            mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        end else begin
            mul_next = acc_q >> 1;
        end

        // The shifted remainder can reach 2*divisor, hence the extra bit; the
        // difference kept on success is always below the divisor.
        div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge     = div_rem_sh >= {1'b0, opnd_q};
        div_diff   = WIDTH'(div_rem_sh - {1'b0, opnd_q});
        if (div_ge) begin
            div_next = {1'b0, div_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {1'b0, div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // -------------------------------------------------------------------------
    // Sign correction applied in FIX
    // -------------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        prod_fix = neg_q     ? -acc_q[2*WIDTH-1:0]     : acc_q[2*WIDTH-1:0];
        quot_fix = neg_q     ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    // NOTE: registers are updated with non-blocking assignments so every
    // right-hand side reads the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the work registers are reset too, not only the control
            // state, so an aborted operation leaves nothing behind.
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            acc_q         <= '0;
            opnd_q        <= '0;
            is_div_q      <= 1'b0;
            neg_q         <= 1'b0;
            rem_neg_q     <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    // MTHI/MTLO are only honoured here; while busy the stalled
                    // pipeline presents them again later.
                    if (hi_we) begin
                        hi_q <= data1;
                    end
                    if (lo_we) begin
                        lo_q <= data1;
                    end

                    if (start) begin
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        is_div_q  <= op_is_div;
                        neg_q     <= sgn1 ^ sgn2;
                        rem_neg_q <= sgn1;
                        if (op_is_div) begin
                            acc_q  <= {{(WIDTH + 1){1'b0}}, mag1};
                            opnd_q <= mag2;
                        end else begin
                            acc_q  <= {{(WIDTH + 1){1'b0}}, mag2};
                            opnd_q <= mag1;
                        end
                        if (op_is_div && (data2 == '0)) begin
                            dbz_q   <= 1'b1;
                            state_q <= S_FIX;
                        end else begin
                            dbz_q   <= 1'b0;
                            state_q <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITER - 1)) begin
                        state_q <= S_FIX;
                    end
                end

                S_FIX: begin
                    if (!dbz_q) begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                    done_q        <= 1'b1;
                    div_by_zero_q <= dbz_q;
                    dbz_q         <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign busy        = busy_q;
    assign stall       = busy_q & (start | hilo_rd | hi_we | lo_we);
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit beside the ALU in the EX stage.
- Sequences a 32-iteration shift-add multiplier and a restoring divider.
- Owns the HI/LO registers and raises a stall to the hazard logic while an operation is in flight.
- Serves MULT, MULTU, DIV, DIVU, MTHI, MTLO and MFHI/MFLO reads.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- ITER, 32, iterations per operation; must equal WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  issue the operation in op; sampled on the clock edge.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- data1  input  WIDTH  rs operand (multiplicand/dividend); also MTHI/MTLO write data.
- data2  input  WIDTH  rt operand (multiplier/divisor).
- hi_we  input  1  MTHI: HI <= data1.
- lo_we  input  1  MTLO: LO <= data1.
- hilo_rd  input  1  EX instruction is MFHI/MFLO.
- busy  output  1  operation in flight.
- stall  output  1  combinational; freeze IF/ID/EX.
- done  output  1  one-cycle pulse when HI/LO updated.
- div_by_zero  output  1  one-cycle pulse with done on DIV/DIVU with data2==0.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; busy, done, div_by_zero = 0.
  - hi, lo, iteration counter and work registers = 0.
- States:
  - IDLE: accept start; busy=0.
  - RUN: one iteration per cycle, counter 0..ITER-1.
  - FIX: sign correction and HI/LO write.
- IDLE -> RUN: start=1 at edge E0.
  - Latch magnitudes: |data1|, |data2| for signed ops; raw values for unsigned ops.
  - Latch result sign: op MULT = data1[31]^data2[31]; DIV quotient same rule, remainder sign = data1[31].
  - Clear the 64-bit accumulator/remainder and the counter; busy=1 after E0.
- Divide by zero: start with op DIV/DIVU and data2==0 goes IDLE -> FIX directly.
  - HI/LO unchanged.
  - done=1 and div_by_zero=1 after E1.
- RUN, edges E1..E32:
  - Multiply: if multiplier LSB set, add multiplicand to the upper half of the 65-bit accumulator, then shift right 1.
  - Divide: shift remainder:quotient left 1, trial-subtract divisor from the remainder, keep if non-negative and set quotient LSB.
  - After counter==ITER-1 at E32, go to FIX.
- FIX, edge E33:
  - Negate the 64-bit product if the sign is set.
  - Negate quotient/remainder per their latched signs.
  - Multiply: HI = product[63:32], LO = product[31:0]. Divide: LO = quotient, HI = remainder.
  - done=1 for exactly the cycle after E33; state -> IDLE, busy=0 in that same cycle.
- Latency: start to valid HI/LO is 34 edges (E0..E33); busy high for 33 cycles.
- Arithmetic boundaries:
  - 0x80000000 handled as unsigned magnitude 0x80000000 (no overflow in the abs step).
  - DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0, no flag.
- stall = busy & (start | hilo_rd | hi_we | lo_we).
  - start, hi_we and lo_we while busy are ignored; the stalled pipeline re-presents them.
- start asserted in the cycle done=1: accepted (state is IDLE).
- hi_we/lo_we in IDLE: register written at the edge. If asserted together with start, the MTHI/MTLO write happens and the start is still accepted.
- hi/lo outputs hold their last written values throughout RUN and FIX; no intermediate values are exposed.

Test Plan:
- MULT data1=7, data2=0xFFFFFFFD (-3) -> after E33: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1 for one cycle, busy high exactly 33 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; MULT of the same operands -> hi=0, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 100/0 with prior hi=0x11, lo=0x22 -> done and div_by_zero pulse after E1, hi/lo unchanged, busy one cycle.
- During RUN:
  - hilo_rd=1 -> stall=1 until the done cycle.
  - second start -> ignored; hi/lo reflect only the first op.
  - lo_we=1 -> lo unchanged.
- rst pulsed asynchronously (mid-cycle) at iteration 10 -> busy=0, hi=lo=0 immediately; next start completes normally in 34 edges.
